// File: rtl/ift_operand_fifo.sv
// ============================================================================
// Module   : ift_operand_fifo
// Purpose  : First-word-fall-through operand-pair FIFO with IFT tag tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ift_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 1,
    parameter int TW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tag_clr,
    input  logic                       in_valid,
    input  logic [TW-1:0]              in_valid_t,
    output logic                       in_ready,
    output logic [TW-1:0]              in_ready_t,
    input  logic [DW-1:0]              in_a,
    input  logic [TW-1:0]              in_a_t,
    input  logic [DW-1:0]              in_b,
    input  logic [TW-1:0]              in_b_t,
    output logic                       out_valid,
    output logic [TW-1:0]              out_valid_t,
    input  logic                       out_ready,
    input  logic [TW-1:0]              out_ready_t,
    output logic [DW-1:0]              out_a,
    output logic [TW-1:0]              out_a_t,
    output logic [DW-1:0]              out_b,
    output logic [TW-1:0]              out_b_t,
    output logic [$clog2(DEPTH):0]     count,
    output logic [TW-1:0]              count_t
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [TW-1:0] r_ctl_t;

    logic [DW-1:0] r_mem_a  [DEPTH];
    logic [TW-1:0] r_mem_at [DEPTH];
    logic [DW-1:0] r_mem_b  [DEPTH];
    logic [TW-1:0] r_mem_bt [DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ctl_t  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Handshake tags are absorbed whenever observed, transfer or not.
            if (tag_clr)
                r_ctl_t <= '0;
            else
                r_ctl_t <= r_ctl_t
                         | (in_ready  ? in_valid_t  : '0)
                         | (out_valid ? out_ready_t : '0);
        end
    end

    // Storage is deliberately unreset; the read side masks it while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[w_wr_idx]  <= in_a;
            r_mem_at[w_wr_idx] <= in_a_t | in_valid_t;
            r_mem_b[w_wr_idx]  <= in_b;
            r_mem_bt[w_wr_idx] <= in_b_t | in_valid_t;
        end
    end

    assign out_a   = w_empty ? '0 : r_mem_a[w_rd_idx];
    assign out_b   = w_empty ? '0 : r_mem_b[w_rd_idx];
    assign out_a_t = w_empty ? r_ctl_t : (r_mem_at[w_rd_idx] | r_ctl_t);
    assign out_b_t = w_empty ? r_ctl_t : (r_mem_bt[w_rd_idx] | r_ctl_t);

    assign count       = r_wr_ptr - r_rd_ptr;
    assign count_t     = r_ctl_t;
    assign in_ready_t  = r_ctl_t;
    assign out_valid_t = r_ctl_t;

endmodule

`default_nettype wire

// File: tb/tb_ift_operand_fifo.sv
// Directed self-checking bench for ift_operand_fifo (DEPTH=4, DW=1, TW=32).
`default_nettype none

module tb_ift_operand_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tag_clr;
    logic        in_valid;
    logic [31:0] in_valid_t;
    logic        in_ready;
    logic [31:0] in_ready_t;
    logic        in_a;
    logic [31:0] in_a_t;
    logic        in_b;
    logic [31:0] in_b_t;
    logic        out_valid;
    logic [31:0] out_valid_t;
    logic        out_ready;
    logic [31:0] out_ready_t;
    logic        out_a;
    logic [31:0] out_a_t;
    logic        out_b;
    logic [31:0] out_b_t;
    logic [2:0]  count;
    logic [31:0] count_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    ift_operand_fifo #(.DEPTH(4), .DW(1), .TW(32)) dut (
        .clk(clk), .rst_n(rst_n), .tag_clr(tag_clr),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .out_a(out_a), .out_a_t(out_a_t), .out_b(out_b), .out_b_t(out_b_t),
        .count(count), .count_t(count_t)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tag_clr = 1'b0; in_valid = 1'b0; in_valid_t = '0;
        in_a = 1'b0; in_a_t = '0; in_b = 1'b0; in_b_t = '0;
        out_ready = 1'b0; out_ready_t = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0)
            $display("FAIL reset_ctl: got valid=%b ready=%b count=%0d required 0/1/0",
                     out_valid, in_ready, count);
        else n_pass++;
        n_checks++;
        if ((out_a_t | out_b_t | count_t | in_ready_t | out_valid_t) !== 32'h0 ||
            out_a !== 1'b0 || out_b !== 1'b0)
            $display("FAIL reset_tags: got a_t=%h b_t=%h cnt_t=%h a=%b b=%b required all 0",
                     out_a_t, out_b_t, count_t, out_a, out_b);
        else n_pass++;
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_a = 1'b1; in_a_t = 32'h1; in_b = 1'b0; in_b_t = 32'h2;
        step();
        in_valid = 1'b0; in_a_t = '0; in_b_t = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_a !== 1'b1 || out_b !== 1'b0 || count !== 3'd1)
            $display("FAIL single_data: got valid=%b a=%b b=%b count=%0d required 1/1/0/1",
                     out_valid, out_a, out_b, count);
        else n_pass++;
        n_checks++;
        if (out_a_t !== 32'h1 || out_b_t !== 32'h2)
            $display("FAIL single_tags: got a_t=%h b_t=%h required 1/2", out_a_t, out_b_t);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL single_pop: got count=%0d valid=%b required 0/0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = i[0]; in_a_t = 32'h100 + i;
            in_b = ~i[0]; in_b_t = 32'h200 + i;
            step();
        end
        in_valid = 1'b0; in_a_t = '0; in_b_t = '0;
        n_checks++;
        if (in_ready !== 1'b0 || count !== 3'd4)
            $display("FAIL full: got ready=%b count=%0d required 0/4", in_ready, count);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_a !== i[0] || out_b !== ~i[0] ||
                out_a_t !== 32'h100 + i || out_b_t !== 32'h200 + i)
                $display("FAIL drain_%0d: got v=%b a=%b b=%b a_t=%h b_t=%h required 1/%b/%b/%h/%h",
                         i, out_valid, out_a, out_b, out_a_t, out_b_t,
                         i[0], ~i[0], 32'h100 + i, 32'h200 + i);
            else n_pass++;
            step();
        end
        step();  // pop while empty must be ignored
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL drained: got valid=%b count=%0d ready=%b required 0/0/1",
                     out_valid, count, in_ready);
        else n_pass++;
    endtask

    task automatic test_implicit_taint();
        in_valid = 1'b1; in_valid_t = 32'h8; in_a = 1'b1; in_b = 1'b1;
        step();
        in_valid = 1'b0; in_valid_t = '0;
        n_checks++;
        if (out_a_t !== 32'h8 || out_b_t !== 32'h8 || count_t !== 32'h8 ||
            out_valid_t !== 32'h8 || in_ready_t !== 32'h8)
            $display("FAIL taint_push: got a_t=%h b_t=%h cnt_t=%h v_t=%h r_t=%h required 8",
                     out_a_t, out_b_t, count_t, out_valid_t, in_ready_t);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || count_t !== 32'h8 || out_a_t !== 32'h8 || in_ready_t !== 32'h8)
            $display("FAIL taint_sticky: got count=%0d cnt_t=%h a_t=%h r_t=%h required 0/8/8/8",
                     count, count_t, out_a_t, in_ready_t);
        else n_pass++;
        tag_clr = 1'b1;
        step();
        tag_clr = 1'b0;
        n_checks++;
        if (count_t !== 32'h0 || out_valid_t !== 32'h0 || out_b_t !== 32'h0)
            $display("FAIL taint_clr: got cnt_t=%h v_t=%h b_t=%h required 0",
                     count_t, out_valid_t, out_b_t);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        for (int j = 0; j < 2; j++) begin
            t = 32'h300 + j;
            in_valid = 1'b1; in_a = t[0]; in_a_t = t;
            step();
            exp_q.push_back(t);
        end
        out_ready = 1'b1;
        for (int j = 2; j < 12; j++) begin
            t = 32'h300 + j;
            in_a = t[0]; in_a_t = t;
            n_checks++;
            if (out_a_t !== exp_q[0] || out_a !== exp_q[0][0] || count !== 3'd2)
                $display("FAIL b2b_%0d: got a_t=%h a=%b count=%0d required %h/%b/2",
                         j, out_a_t, out_a, count, exp_q[0], exp_q[0][0]);
            else n_pass++;
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(t);
        end
        in_valid = 1'b0; out_ready = 1'b0; in_a_t = '0;
        n_checks++;
        if (count !== 3'd2 || out_a_t !== exp_q[0])
            $display("FAIL b2b_end: got count=%0d a_t=%h required 2/%h", count, out_a_t, exp_q[0]);
        else n_pass++;
        out_ready_t = 32'h10;
        step();
        out_ready_t = '0;
        n_checks++;
        if (count_t !== 32'h10 || out_a_t !== (exp_q[0] | 32'h10) || count !== 3'd2)
            $display("FAIL ready_taint: got cnt_t=%h a_t=%h count=%0d required 10/%h/2",
                     count_t, out_a_t, count, exp_q[0] | 32'h10);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        tag_clr = 1'b1;
        step();
        tag_clr = 1'b0;
        in_valid = 1'b1; in_valid_t = 32'h8; in_a = 1'b0; in_a_t = '0;
        step();
        in_valid = 1'b0; in_valid_t = '0;
        n_checks++;
        if (count !== 3'd3 || count_t !== 32'h8)
            $display("FAIL pre_reset: got count=%0d cnt_t=%h required 3/8", count, count_t);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 ||
            count_t !== 32'h0 || out_a_t !== 32'h0 || out_b_t !== 32'h0)
            $display("FAIL async_reset: got v=%b count=%0d r=%b cnt_t=%h a_t=%h b_t=%h required 0/0/1/0/0/0",
                     out_valid, count, in_ready, count_t, out_a_t, out_b_t);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_a !== 1'b0)
            $display("FAIL post_reset: got v=%b count=%0d a=%b required 0/0/0",
                     out_valid, count, out_a);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_implicit_taint();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ift_operand_fifo.md
Name: ift_operand_fifo

Overview:
- Tag-tracking first-word-fall-through FIFO that buffers operand pairs {a, b} with their 32-bit IFT tags.
- Sits directly upstream of the tagged binary-operator stage and drives its a/a_t/b/b_t inputs.
- Propagates data tags together with implicit-flow tags from the handshake controls (in_valid_t, out_ready_t). Downstream tag logic therefore sees every taint that influenced which operand is presented.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- DW, 1, operand data width.
- TW, 32, tag width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tag_clr  input  1  synchronous clear of the control-tag register (declassify).
- in_valid  input  1  producer has an operand pair.
- in_valid_t  input  TW  tag of in_valid.
- in_ready  output  1  FIFO can accept a pair.
- in_ready_t  output  TW  tag of in_ready.
- in_a  input  DW  operand a.
- in_a_t  input  TW  tag of in_a.
- in_b  input  DW  operand b.
- in_b_t  input  TW  tag of in_b.
- out_valid  output  1  head entry valid.
- out_valid_t  output  TW  tag of out_valid.
- out_ready  input  1  consumer accepts head.
- out_ready_t  input  TW  tag of out_ready.
- out_a  output  DW  head operand a.
- out_a_t  output  TW  head a tag.
- out_b  output  DW  head operand b.
- out_b_t  output  TW  head b tag.
- count  output  clog2(DEPTH)+1  occupancy.
- count_t  output  TW  tag of count.

Behaviour:
- Reset: rst_n is asynchronous, active-low, single clock domain.
  - While rst_n=0: rd/wr pointers=0, ctl_t=0, count=0, out_valid=0, in_ready=1, out_a=out_b=0, and all *_t outputs=0.
  - Memory contents are not reset; outputs are masked while empty.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)+1 bits, with the MSB as a wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Handshake:
  - in_ready = !full and out_valid = !empty, both from registered state only.
  - in_ready does not depend on out_ready, so no push is accepted while full, even with a pop in the same cycle.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage on push:
  - mem[wr] stores a = in_a, a_t = in_a_t | in_valid_t, b = in_b, b_t = in_b_t | in_valid_t.
  - wr_ptr increments.
- Read: on pop, rd_ptr increments.
  - Latency: a pair pushed at edge k appears on out_* in the cycle after edge k (first-word fall-through, zero read latency).
- count: wr_ptr - rd_ptr. Push and pop in the same cycle leave count unchanged.
- Control tag register ctl_t (TW bits), evaluated each edge:
  - If tag_clr=1, ctl_t becomes 0 (tag_clr takes priority).
  - Otherwise ctl_t becomes ctl_t | (in_ready ? in_valid_t : 0) | (out_valid ? out_ready_t : 0).
  - This is accumulated every cycle the control is observed, whether or not a transfer occurs.
  - ctl_t is sticky until rst_n or tag_clr.
- Tag outputs:
  - count_t = in_ready_t = out_valid_t = ctl_t.
  - When !empty: out_a_t = mem[rd].a_t | ctl_t and out_b_t = mem[rd].b_t | ctl_t.
  - When empty: out_a = out_b = 0 and out_a_t = out_b_t = ctl_t.
- Boundaries:
  - Push while full is ignored; the producer holds its data.
  - Pop while empty is ignored.
  - Push into an empty FIFO sets out_valid=1 the next cycle.
  - Push and pop together at count=DEPTH-1 give a net count of DEPTH-1.
  - rst_n asserted mid-operation clears pointers and ctl_t immediately, without waiting for a clock edge. Buffered entries are discarded.
- Data-to-tag widths: the *_t signals are per-operand, not per-bit. The DW data bits share one TW tag.

Test Plan:
- Reset: hold rst_n=0, then release → out_valid=0, in_ready=1, count=0, and every *_t output = 0x00000000.
- Single push: in_a=1, in_a_t=0x1, in_b=0, in_b_t=0x2, in_valid_t=0, out_ready=0 → next cycle out_valid=1, out_a=1, out_a_t=0x1, out_b=0, out_b_t=0x2, count=1.
- Fill and drain (untainted controls):
  - Push pairs P0..P4 → after 4 pushes full, in_ready=0, P4 not accepted.
  - Pops return P0, P1, P2, P3 in order, then out_valid=0 and count=0.
- Implicit taint: push with in_valid_t=0x8 and data tags 0 →
  - stored a_t=b_t=0x8, and count_t=out_valid_t=in_ready_t=0x8;
  - these remain 0x8 after the entry is popped;
  - one tag_clr pulse returns them to 0.
- Concurrency and wrap:
  - At count=2, push and pop in the same cycle for 10 consecutive cycles → count stays 2, FIFO order preserved across pointer wrap.
  - out_ready_t=0x10 asserted while out_valid=1 → ctl_t gains 0x10 even on cycles with out_ready=0.
- Async reset mid-stream: count=3 with ctl_t=0x8, drop rst_n between clock edges → outputs go to reset values before the next edge, and the FIFO reads empty after release.
